// File: rtl/flipper_pkg.sv
// Shared board definitions for the move engines (validator and flipper).
// Cell encodings, padded-board geometry and the eight walk directions.
// Helpers keep colour and address arithmetic identical across engines.
package flipper_pkg;

   // Two-bit cell codes stored in the board RAM
   localparam logic [1:0] EMPTY  = 2'b00;
   localparam logic [1:0] BLACK  = 2'b01;
   localparam logic [1:0] WHITE  = 2'b10;
   localparam logic [1:0] BORDER = 2'b11;

   // 8x8 playfield padded with a one-cell border ring: address = 10*row + col
   localparam int BOARD_STRIDE = 10;

   // Direction steps, 5-bit two's complement
   localparam logic [4:0] STEP_E  = 5'b00001;  // +1
   localparam logic [4:0] STEP_W  = 5'b11111;  // -1
   localparam logic [4:0] STEP_S  = 5'b01010;  // +10
   localparam logic [4:0] STEP_N  = 5'b10110;  // -10
   localparam logic [4:0] STEP_SW = 5'b01001;  // +9
   localparam logic [4:0] STEP_NE = 5'b10111;  // -9
   localparam logic [4:0] STEP_SE = 5'b01011;  // +11
   localparam logic [4:0] STEP_NW = 5'b10101;  // -11

   // Colour code of the side to move
   function automatic logic [1:0] own_colour(input logic p);
      return p ? WHITE : BLACK;
   endfunction

   // Colour code of the side not to move
   function automatic logic [1:0] opp_colour(input logic p);
      return p ? BLACK : WHITE;
   endfunction

   // Next address along a direction; wraps modulo 128, border cells stop walks
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic [4:0] s);
      return a + {{2{s[4]}}, s};
   endfunction

endpackage

// File: rtl/flipper.sv
// Purpose: walks one confirmed capture line, overwriting opponent discs with the mover's colour.
// Latency: done_o at cycle 3+3n (4+3n with place_in) after the accepted start, n = discs flipped.
// Backpressure: none; enable is only sampled in idle and the board RAM is owned while busy.
module flipper
   import flipper_pkg::*;
#(
   parameter int MAX_FLIPS = 6
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] s_addr_in,
   input  logic [4:0] step_in,
   input  logic       player,
   input  logic       place_in,
   input  logic [1:0] data_in,
   output logic [6:0] addr_out,
   output logic [1:0] data_out,
   output logic       wren_o,
   output logic       ctrl_mem,
   output logic       done_o,
   output logic       ok_o,
   output logic [3:0] flip_count_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PLACE = 3'd1;
   localparam logic [2:0] S_STEP  = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [3:0] FLIP_LIMIT = 4'(MAX_FLIPS);

   // Walk context latched at start
   logic [2:0] state,     state_nxt;
   logic [6:0] addr,      addr_nxt;
   logic [4:0] step,      step_nxt;
   logic       mover,     mover_nxt;
   logic [3:0] count,     count_nxt;
   logic       ok,        ok_nxt;

   // Bus outputs are registered; these are their next values
   logic [6:0] addr_out_nxt;
   logic [1:0] data_out_nxt;
   logic       wren_nxt;
   logic       done_nxt;

   logic [1:0] own;
   logic [1:0] opp;
   logic [6:0] walk_addr;

   assign own       = own_colour(mover);
   assign opp       = opp_colour(mover);
   assign walk_addr = step_addr(addr, step);

   // Next-state and next-output decode; outputs are computed one cycle ahead so they leave flops
   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr;
      step_nxt     = step;
      mover_nxt    = mover;
      count_nxt    = count;
      ok_nxt       = ok;
      addr_out_nxt = 7'd0;
      data_out_nxt = EMPTY;
      wren_nxt     = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            if (enable) begin
               step_nxt  = step_in;
               mover_nxt = player;
               count_nxt = 4'd0;
               ok_nxt    = 1'b0;
               if (place_in) begin
                  // Drop the mover's disc on the start square first
                  state_nxt    = S_PLACE;
                  addr_nxt     = s_addr_in;
                  addr_out_nxt = s_addr_in;
                  data_out_nxt = own_colour(player);
                  wren_nxt     = 1'b1;
               end else begin
                  // Go straight to the first neighbour read
                  state_nxt    = S_STEP;
                  addr_nxt     = step_addr(s_addr_in, step_in);
                  addr_out_nxt = step_addr(s_addr_in, step_in);
               end
            end
         end

         S_PLACE, S_WRITE: begin
            // Advance to the next cell along the line and present its read address
            state_nxt    = S_STEP;
            addr_nxt     = walk_addr;
            addr_out_nxt = walk_addr;
            if (state == S_WRITE) begin
               count_nxt = count + 4'd1;
            end
         end

         S_STEP: begin
            // Hold the read address while the RAM returns the cell
            state_nxt    = S_READ;
            addr_out_nxt = addr;
         end

         S_READ: begin
            if (data_in == opp && count < FLIP_LIMIT) begin
               state_nxt    = S_WRITE;
               addr_out_nxt = addr;
               data_out_nxt = own;
               wren_nxt     = 1'b1;
            end else begin
               // Own disc closes the capture; anything else (or a too-long run) aborts without rollback
               state_nxt = S_DONE;
               done_nxt  = 1'b1;
               ok_nxt    = (data_in == own);
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, context and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= S_IDLE;
         addr     <= 7'd0;
         step     <= 5'd0;
         mover    <= 1'b0;
         count    <= 4'd0;
         ok       <= 1'b0;
         addr_out <= 7'd0;
         data_out <= EMPTY;
         wren_o   <= 1'b0;
         ctrl_mem <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         step     <= step_nxt;
         mover    <= mover_nxt;
         count    <= count_nxt;
         ok       <= ok_nxt;
         addr_out <= addr_out_nxt;
         data_out <= data_out_nxt;
         wren_o   <= wren_nxt;
         ctrl_mem <= (state_nxt != S_IDLE);
         done_o   <= done_nxt;
      end
   end

   assign ok_o         = ok;
   assign flip_count_o = count;

   // Completion is a single-cycle pulse
   a_done_pulse: assert property (@(posedge clock) disable iff (!reset) done_o |=> !done_o);

   // Writes only happen while the bus is held
   a_wren_owned: assert property (@(posedge clock) disable iff (!reset) wren_o |-> ctrl_mem);

endmodule
